// File: rtl/product_accumulator.sv
// product_accumulator: sums a burst of len unsigned products, then holds the result for a valid/ready handshake.
// Define PRODUCT_ACC_SAT_EN to clamp acc to all ones on overflow instead of wrapping.
module product_accumulator #(
   parameter int m     = 16,
   parameter int n     = 16,
   parameter int G     = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [m+n-1:0]   product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [m+n+G-1:0] acc,
   output logic             ovf,
   output logic             busy
);
   localparam int W = m + n + G;
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
   state_t           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d, add;
   logic             ovf_q, ovf_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [W:0]       sum;
   logic             beat;
   assign sum  = {1'b0, acc_q} + {{(G + 1){1'b0}}, product};
`ifdef PRODUCT_ACC_SAT_EN
   assign add  = sum[W] ? '1 : sum[W-1:0];
`else
   assign add  = sum[W-1:0];
`endif
   assign beat = in_valid && state_q == ACC;
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (abort) begin
         state_d = IDLE;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else if (state_q == IDLE && start) begin
         state_d = len == '0 ? HOLD : ACC;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = len;
      end else if (beat) begin
         state_d = cnt_q == LEN_W'(1) ? HOLD : ACC;
         acc_d   = add;
         ovf_d   = ovf_q | sum[W];
         cnt_d   = cnt_q - LEN_W'(1);
      end else if (state_q == HOLD && out_ready) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end
   assign in_ready  = state_q == ACC;
   assign out_valid = state_q == HOLD;
   assign busy      = state_q != IDLE;
   assign acc       = acc_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: randomized and directed bursts against an arithmetic reference of the burst sum.
// LEN_W is widened to 9 so a 300-beat burst can drive the 40-bit accumulator past its range.
module tb_product_accumulator;
   localparam int M = 16, N = 16, G = 8, LW = 9, W = M + N + G;
   localparam longint unsigned MOD = 64'd1 << W;
   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic [LW-1:0] len = '0;
   logic [M+N-1:0] product = '0;
   logic          in_ready, out_valid, ovf, busy;
   logic [W-1:0]  acc;
   int            tests = 0, fails = 0;
   logic [31:0]   pq[$];

   product_accumulator #(.m(M), .n(N), .G(G), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .product(product),
      .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected accumulator value from the true (unbounded) sum of the burst.
   function automatic longint unsigned model_acc(input longint unsigned s);
`ifdef PRODUCT_ACC_SAT_EN
      return s >= MOD ? MOD - 1 : s;
`else
      return s % MOD;
`endif
   endfunction

   task automatic chk_idle(input string tag, input longint unsigned e_acc, input logic e_ovf);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_acc"}, acc, e_acc);
      chk({tag, "_ovf"}, ovf, e_ovf);
   endtask

   // One burst: products from pq (cycled) or random when pq is empty; start is jittered
   // during ACC to show it is ignored; out_ready withheld for `hold` cycles.
   task automatic burst(input string tag, input int nb, input int gap_pct, input int hold);
      longint unsigned s = 0;
      int rem = nb, k = 0;
      start = 1'b1;
      len = LW'(nb);
      tick;
      start = 1'b0;
      while (rem > 0) begin
         chk({tag, "_in_ready"}, in_ready, 1);
         in_valid = ($urandom_range(99) >= gap_pct);
         product = pq.size() > 0 ? pq[k % pq.size()] : $urandom;
         start = 1'($urandom_range(1));
         len = LW'($urandom);
         tick;
         if (in_valid) begin
            s += product;
            rem--;
            k++;
         end
      end
      in_valid = 1'b0;
      start = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         chk({tag, "_out_valid"}, out_valid, 1);
         chk({tag, "_hold_in_ready"}, in_ready, 0);
         chk({tag, "_acc"}, acc, model_acc(s));
         chk({tag, "_ovf"}, ovf, s >= MOD);
         if (i < hold) tick;
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk_idle({tag, "_after"}, model_acc(s), s >= MOD);
   endtask

   initial begin
      #12;
      chk_idle("reset", 0, 0);
      #2 rst_n = 1'b1;
      tick;
      pq = {32'd100, 32'd200, 32'd300};
      burst("nominal", 3, 0, 0);
      pq.delete();
      burst("backpressure", 2, 50, 5);
      burst("len0", 0, 0, 2);
      repeat (4) burst("random", $urandom_range(20, 1), 30, $urandom_range(3));
      pq = {32'hFFFF_FFFF};
      burst("overflow", 300, 0, 1);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk_idle("abort_idle", 0, 0);
      start = 1'b1;
      len = LW'(4);
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      product = 32'd5;
      tick;
      chk("abort_pre_acc", acc, 5);
      abort = 1'b1;
      start = 1'b1;
      product = 32'd9;
      tick;
      abort = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      chk_idle("abort_acc", 0, 0);
      tick;
      chk_idle("abort_nostart", 0, 0);
      start = 1'b1;
      len = LW'(3);
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      product = 32'd11;
      tick;
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk_idle("async_reset", 0, 0);
      #1 rst_n = 1'b1;
      tick;
      chk_idle("post_reset_wait", 0, 0);
      pq = {32'd7};
      burst("after_reset", 1, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
